// File: rtl/cpu_mc_pkg.sv
// ============================================================================
// Module      : cpu_mc_pkg
// Description : Shared types and encodings for the multi-cycle RV32I-subset core
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_e;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2
    } imm_fmt_e;

    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] C_F3_ADD = 3'b000;
    localparam logic [2:0] C_F3_LW  = 3'b010;
    localparam logic [2:0] C_F3_SW  = 3'b010;
    localparam logic [2:0] C_F3_BEQ = 3'b000;
    localparam logic [2:0] C_F3_BNE = 3'b001;

    localparam logic [6:0] C_F7_ADD = 7'b0000000;
    localparam logic [6:0] C_F7_SUB = 7'b0100000;

    // 32-bit sign-extended immediate; callers widen it to the datapath width
    function automatic logic [31:0] imm32(input imm_fmt_e fmt, input logic [31:0] ir);
        logic [31:0] v;
        case (fmt)
            IMM_S:   v = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   v = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default: v = {{20{ir[31]}}, ir[31:20]};
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_regfile.sv
// ============================================================================
// Module      : mc_regfile
// Description : 32-entry register file, two async reads, one sync write, x0=0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_regfile #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  we,
    input  logic [4:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] a0
);

    logic [DATA_WIDTH-1:0] r_regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (rd_addr != 5'd0)) begin
            r_regs[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : r_regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : r_regs[rs2_addr];
    assign a0       = r_regs[10];

endmodule

`default_nettype wire

// File: rtl/cpu_multicycle.sv
// ============================================================================
// Module      : cpu_multicycle
// Description : Multi-cycle RV32I-subset core with shared ALU and memory port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_multicycle
    import cpu_mc_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic [DATA_WIDTH-1:0] a0,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  retired
);

    state_e                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [31:0]           r_ir, w_ir_nxt;
    logic [DATA_WIDTH-1:0] r_a, w_a_nxt;
    logic [DATA_WIDTH-1:0] r_b, w_b_nxt;
    logic [DATA_WIDTH-1:0] r_imm, w_imm_nxt;
    logic [DATA_WIDTH-1:0] r_res, w_res_nxt;
    logic                  r_mem_req, w_req_nxt;
    logic                  r_mem_we, w_we_nxt;
    logic [DATA_WIDTH-1:0] r_mem_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_wdata_nxt;
    logic                  r_halted, w_halt_nxt;
    logic [CNT_WIDTH-1:0]  r_retired;
    logic                  w_retire;

    logic [6:0]            w_opc;
    logic [2:0]            w_f3;
    logic [6:0]            w_f7;
    logic                  w_legal;
    imm_fmt_e              w_fmt;
    alu_op_e               w_alu_op;
    logic [DATA_WIDTH-1:0] w_alu_b, w_alu_y;
    logic [DATA_WIDTH-1:0] w_pc4, w_target, w_br_pc;
    logic                  w_taken;
    logic [DATA_WIDTH-1:0] w_rs1_data, w_rs2_data;

    assign w_opc = r_ir[6:0];
    assign w_f3  = r_ir[14:12];
    assign w_f7  = r_ir[31:25];

    mc_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (r_ir[19:15]),
        .rs2_addr (r_ir[24:20]),
        .rs1_data (w_rs1_data),
        .rs2_data (w_rs2_data),
        .we       (r_state == S_WB),
        .rd_addr  (r_ir[11:7]),
        .rd_data  (r_res),
        .a0       (a0)
    );

    always_comb begin
        w_legal = 1'b0;
        w_fmt   = IMM_I;
        case (w_opc)
            C_OPC_OP:     w_legal = (w_f3 == C_F3_ADD) && ((w_f7 == C_F7_ADD) || (w_f7 == C_F7_SUB));
            C_OPC_OP_IMM: w_legal = (w_f3 == C_F3_ADD);
            C_OPC_LOAD:   w_legal = (w_f3 == C_F3_LW);
            C_OPC_STORE: begin
                w_legal = (w_f3 == C_F3_SW);
                w_fmt   = IMM_S;
            end
            C_OPC_BRANCH: begin
                w_legal = (w_f3 == C_F3_BEQ) || (w_f3 == C_F3_BNE);
                w_fmt   = IMM_B;
            end
            default:      w_legal = 1'b0;
        endcase
    end

    // One ALU serves R-type, ADDI and load/store address generation
    assign w_alu_op = ((w_opc == C_OPC_OP) && (w_f7 == C_F7_SUB)) ? ALU_SUB : ALU_ADD;
    assign w_alu_b  = (w_opc == C_OPC_OP) ? r_b : r_imm;
    assign w_alu_y  = (w_alu_op == ALU_SUB) ? (r_a - w_alu_b) : (r_a + w_alu_b);

    assign w_pc4    = r_pc + DATA_WIDTH'(4);
    assign w_target = r_pc + r_imm;
    assign w_taken  = (w_f3 == C_F3_BEQ) ? (r_a == r_b) : (r_a != r_b);
    assign w_br_pc  = w_taken ? w_target : w_pc4;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_imm_nxt   = r_imm;
        w_res_nxt   = r_res;
        w_req_nxt   = r_mem_req;
        w_we_nxt    = r_mem_we;
        w_addr_nxt  = r_mem_addr;
        w_wdata_nxt = r_mem_wdata;
        w_halt_nxt  = r_halted;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                // Only the first fetch after reset arrives here with no request pending
                if (!r_mem_req) begin
                    w_req_nxt  = 1'b1;
                    w_we_nxt   = 1'b0;
                    w_addr_nxt = r_pc;
                end else if (mem_valid) begin
                    w_ir_nxt    = mem_rdata[31:0];
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_a_nxt   = w_rs1_data;
                w_b_nxt   = w_rs2_data;
                w_imm_nxt = DATA_WIDTH'(signed'(imm32(w_fmt, r_ir)));
                if (w_legal) begin
                    w_state_nxt = S_EXECUTE;
                end else begin
                    w_state_nxt = S_HALT;
                    w_halt_nxt  = 1'b1;
                end
            end
            S_EXECUTE: begin
                case (w_opc)
                    C_OPC_LOAD, C_OPC_STORE: begin
                        if (w_alu_y[1:0] != 2'b00) begin
                            w_state_nxt = S_HALT;
                            w_halt_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_MEM;
                            w_req_nxt   = 1'b1;
                            w_we_nxt    = (w_opc == C_OPC_STORE);
                            w_addr_nxt  = w_alu_y;
                            w_wdata_nxt = (w_opc == C_OPC_STORE) ? r_b : '0;
                        end
                    end
                    C_OPC_BRANCH: begin
                        if (w_taken && (w_target[1:0] != 2'b00)) begin
                            w_state_nxt = S_HALT;
                            w_halt_nxt  = 1'b1;
                        end else begin
                            w_pc_nxt    = w_br_pc;
                            w_retire    = 1'b1;
                            w_state_nxt = S_FETCH;
                            w_req_nxt   = 1'b1;
                            w_we_nxt    = 1'b0;
                            w_addr_nxt  = w_br_pc;
                        end
                    end
                    default: begin
                        w_res_nxt   = w_alu_y;
                        w_state_nxt = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                if (r_mem_req && mem_valid) begin
                    w_req_nxt = 1'b0;
                    w_we_nxt  = 1'b0;
                    if (r_mem_we) begin
                        w_pc_nxt    = w_pc4;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = w_pc4;
                    end else begin
                        w_res_nxt   = DATA_WIDTH'(signed'(mem_rdata[31:0]));
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                w_pc_nxt    = w_pc4;
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
                w_req_nxt   = 1'b1;
                w_we_nxt    = 1'b0;
                w_addr_nxt  = w_pc4;
            end
            default: begin
                w_state_nxt = S_HALT;
                w_req_nxt   = 1'b0;
                w_we_nxt    = 1'b0;
                w_halt_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_res       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_halted    <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_imm       <= w_imm_nxt;
            r_res       <= w_res_nxt;
            r_mem_req   <= w_req_nxt;
            r_mem_we    <= w_we_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_halted    <= w_halt_nxt;
            if (w_retire) begin
                r_retired <= r_retired + CNT_WIDTH'(1);
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign halted    = r_halted;
    assign retired   = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_cpu_multicycle.sv
// ============================================================================
// Module      : tb_cpu_multicycle
// Description : Program-level bench for cpu_multicycle (32- and 64-bit builds)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_multicycle;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        mem_req, mem_we, halted;
    logic [31:0] mem_addr, mem_wdata, a0, retired;
    logic [31:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;

    logic        mem_req_w, mem_we_w, halted_w;
    logic [63:0] mem_addr_w, mem_wdata_w, a0_w;
    logic [63:0] mem_rdata_w = '0;
    logic        mem_valid_w = 1'b0;
    logic [15:0] retired_w;

    cpu_multicycle #(.DATA_WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .a0(a0), .halted(halted), .retired(retired)
    );

    cpu_multicycle #(.DATA_WIDTH(64), .RESET_PC(64'h0), .CNT_WIDTH(16)) dut64 (
        .clk(clk), .rst(rst), .mem_req(mem_req_w), .mem_we(mem_we_w), .mem_addr(mem_addr_w),
        .mem_wdata(mem_wdata_w), .mem_rdata(mem_rdata_w), .mem_valid(mem_valid_w),
        .a0(a0_w), .halted(halted_w), .retired(retired_w)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] e_addi(input int rd, input int rs1, input int imm);
        logic [11:0] i;
        i = imm[11:0];
        return {i, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] e_r(input int f7, input int rd, input int rs1, input int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] e_lw(input int rd, input int rs1, input int imm);
        logic [11:0] i;
        i = imm[11:0];
        return {i, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction

    function automatic logic [31:0] e_sw(input int rs2, input int rs1, input int imm);
        logic [11:0] i;
        i = imm[11:0];
        return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] e_b(input int f3, input int rs1, input int rs2, input int imm);
        logic [12:0] b;
        b = imm[12:0];
        return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'(f3), b[4:1], b[11], 7'b1100011};
    endfunction

    // Zero-wait-or-delayed memory for the 32-bit core, with a store scoreboard
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    logic [31:0] mem [64];
    st_t         st_q [$];
    int          waits = 0;
    int          wcnt  = 0;
    int          reqs  = 0;
    logic        stab_bad = 1'b0;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;

    always @(negedge clk) begin
        mem_valid = 1'b0;
        if (rst || !mem_req) begin
            wcnt = 0;
        end else begin
            if (wcnt == 0) begin
                cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
            end else if (mem_addr !== cap_addr || mem_we !== cap_we ||
                         (cap_we && mem_wdata !== cap_wdata)) begin
                stab_bad = 1'b1;
            end
            if (wcnt >= waits) begin
                mem_valid = 1'b1;
                wcnt = 0;
                reqs++;
                if (mem_we) begin
                    if (st_q.size() == 0) begin
                        chk("store_unexpected", {mem_addr, mem_wdata}, 64'h0);
                    end else begin
                        st_t e;
                        e = st_q.pop_front();
                        chk("store_txn", {mem_addr, mem_wdata}, {e.addr, e.data});
                    end
                    mem[mem_addr[7:2]] = mem_wdata;
                end else begin
                    mem_rdata = mem[mem_addr[7:2]];
                end
            end else begin
                wcnt++;
            end
        end
    end

    logic [31:0] prog64 [4];
    always @(negedge clk) begin
        mem_valid_w = mem_req_w && !rst;
        mem_rdata_w = {32'h0, prog64[mem_addr_w[3:2]]};
    end

    typedef struct packed {
        logic [7:0][31:0] prog;
        logic [3:0]       waits;
        logic [31:0]      a0;
        logic [7:0]       retired;
        logic [7:0]       cycles;
        logic [7:0]       reqs;
        logic             has_st;
        logic [31:0]      st_addr;
        logic [31:0]      st_data;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic set_exp(input int v, input int w, input logic [31:0] ea0, input int r,
                           input int c, input int q);
        vecs[v].waits   = 4'(w);
        vecs[v].a0      = ea0;
        vecs[v].retired = 8'(r);
        vecs[v].cycles  = 8'(c);
        vecs[v].reqs    = 8'(q);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {61'h0, halted, mem_req, mem_we}, 64'h0);
        chk("rst_bus", {mem_addr, mem_wdata}, 64'h0);
        chk("rst_cnt", {retired, a0}, 64'h0);
        chk("rst64", a0_w | mem_addr_w | mem_wdata_w | {45'h0, retired_w, halted_w, mem_req_w, mem_we_w}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int  cyc;
        int  n;
        logic seen;
        for (int i = 0; i < NV; i++) vecs[i] = '0;
        // countdown loop, ends on the zero word after the loop
        vecs[0].prog[0] = e_addi(10, 0, 5);
        vecs[0].prog[1] = e_addi(10, 10, -1);
        vecs[0].prog[2] = e_b(1, 10, 0, -4);
        set_exp(0, 0, 32'd0, 11, 42, 12);
        // store, clobber, reload, copy back to a0; 3 wait states per access
        vecs[1].prog[0] = e_addi(10, 0, 9);
        vecs[1].prog[1] = e_sw(10, 0, 64);
        vecs[1].prog[2] = e_addi(10, 0, 0);
        vecs[1].prog[3] = e_lw(11, 0, 64);
        vecs[1].prog[4] = e_r(0, 10, 11, 0);
        set_exp(1, 3, 32'd9, 5, 48, 8);
        vecs[1].has_st = 1'b1; vecs[1].st_addr = 32'd64; vecs[1].st_data = 32'd9;
        vecs[7] = vecs[1];
        set_exp(7, 0, 32'd9, 5, 24, 8);
        // taken branch to a misaligned target
        vecs[2].prog[0] = e_addi(10, 0, 3);
        vecs[2].prog[1] = e_b(0, 0, 0, 2);
        set_exp(2, 0, 32'd3, 1, 8, 2);
        // misaligned load address
        vecs[3].prog[0] = e_addi(10, 0, 1);
        vecs[3].prog[1] = e_lw(11, 0, 6);
        set_exp(3, 0, 32'd1, 1, 8, 2);
        // write to x0 is discarded
        vecs[4].prog[0] = e_addi(10, 0, 4);
        vecs[4].prog[1] = e_addi(0, 0, 7);
        vecs[4].prog[2] = e_r(0, 10, 0, 0);
        set_exp(4, 0, 32'd0, 3, 15, 4);
        // SUB wraps negative, taken BEQ skips one instruction
        vecs[5].prog[0] = e_addi(10, 0, 3);
        vecs[5].prog[1] = e_addi(11, 0, 10);
        vecs[5].prog[2] = e_r(32, 10, 10, 11);
        vecs[5].prog[3] = e_b(0, 0, 0, 8);
        vecs[5].prog[4] = e_addi(10, 0, 1);
        set_exp(5, 0, 32'hFFFF_FFF9, 4, 18, 5);
        // R-type with unsupported funct7
        vecs[6].prog[0] = e_addi(10, 0, 2);
        vecs[6].prog[1] = e_r(1, 10, 10, 10);
        set_exp(6, 0, 32'd2, 1, 7, 2);

        prog64[0] = e_addi(10, 0, -1);
        prog64[1] = e_r(0, 10, 10, 10);
        prog64[2] = 32'h0;
        prog64[3] = 32'h0;
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;

        // 64-bit build: all-ones then wrap on doubling
        do_reset();
        seen = 1'b0;
        for (int c = 0; c < 100 && !halted_w; c++) begin
            @(posedge clk);
            #1;
            if (retired_w == 16'd1 && !seen) begin
                seen = 1'b1;
                chk("w64_addi_neg1", a0_w, 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        chk("w64_seen_first", {63'h0, seen}, 64'h1);
        chk("w64_halted", {63'h0, halted_w}, 64'h1);
        chk("w64_add_wrap", a0_w, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("w64_retired", {48'h0, retired_w}, 64'd2);

        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < 64; k++) mem[k] = 32'h0;
            for (int k = 0; k < 8; k++) mem[k] = vecs[v].prog[k];
            waits = int'(vecs[v].waits);
            reqs = 0;
            stab_bad = 1'b0;
            if (vecs[v].has_st) st_q.push_back({vecs[v].st_addr, vecs[v].st_data});
            do_reset();
            cyc = 0;
            while (!halted && cyc < 200) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            chk($sformatf("v%0d_halted", v), {63'h0, halted}, 64'h1);
            chk($sformatf("v%0d_cycles", v), 64'(cyc), 64'(vecs[v].cycles));
            chk($sformatf("v%0d_a0", v), {32'h0, a0}, {32'h0, vecs[v].a0});
            chk($sformatf("v%0d_retired", v), {32'h0, retired}, 64'(vecs[v].retired));
            chk($sformatf("v%0d_reqs", v), 64'(reqs), 64'(vecs[v].reqs));
            n = 0;
            repeat (5) begin
                @(posedge clk);
                #1;
                if (mem_req) n++;
            end
            chk($sformatf("v%0d_req_after_halt", v), 64'(n), 64'h0);
            chk($sformatf("v%0d_bus_stable", v), {63'h0, stab_bad}, 64'h0);
        end
        chk("store_queue_drained", 64'(st_q.size()), 64'h0);

        // Reset while a fetch is waiting for mem_valid
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        for (int k = 0; k < 8; k++) mem[k] = vecs[0].prog[k];
        waits = 2;
        do_reset();
        repeat (30) @(posedge clk);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (mem_req && !mem_we && !mem_valid && wcnt > 0 && retired != 0) seen = 1'b1;
        end
        chk("rstmid_found_wait", {63'h0, seen}, 64'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_req_drop", {63'h0, mem_req}, 64'h0);
        chk("rstmid_retired", {32'h0, retired}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        waits = 0;
        @(posedge clk);
        #1;
        chk("rstmid_refetch", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
